// File: rtl/ysyx_24110015_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_arb_pkg
// Shared types and constants for the IFU/LSU memory arbiter.
//   state_e  : arbiter sequencer states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_e  : which master owns the transaction in flight
//   op_e     : read or write transaction
//   RESP_*   : response codes used when the arbiter generates a response itself
// ---------------------------------------------------------------------------
package ysyx_24110015_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_24110015_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_arbiter_if
// Bundles every request/response signal around the arbiter: the IFU read
// channel, the LSU read and write channels, and the SRAM read/write ports.
//   modport slave  : the arbiter's view (takes master requests and SRAM
//                    responses, drives readies, responses and SRAM strobes)
//   modport master : the environment's view (IFU, LSU and SRAM model)
// Parameters: ADDR_WIDTH, DATA_WIDTH (strobe width is DATA_WIDTH/8).
// ---------------------------------------------------------------------------
interface ysyx_24110015_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // IFU read channel
    logic                  ifu_arvalid;
    logic [ADDR_WIDTH-1:0] ifu_araddr;
    logic                  ifu_arready;
    logic                  ifu_rvalid;
    logic [DATA_WIDTH-1:0] ifu_rdata;
    logic [1:0]            ifu_rresp;

    // LSU read channel
    logic                  lsu_arvalid;
    logic [ADDR_WIDTH-1:0] lsu_araddr;
    logic                  lsu_arready;
    logic                  lsu_rvalid;
    logic [DATA_WIDTH-1:0] lsu_rdata;
    logic [1:0]            lsu_rresp;

    // LSU write channel
    logic                  lsu_awvalid;
    logic [ADDR_WIDTH-1:0] lsu_awaddr;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [STRB_WIDTH-1:0] lsu_wstrb;
    logic                  lsu_awready;
    logic                  lsu_bvalid;
    logic [1:0]            lsu_bresp;

    // SRAM ports
    logic [ADDR_WIDTH-1:0] sram_araddr;
    logic                  sram_ren;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic [1:0]            sram_rresp;
    logic                  sram_rvalid;
    logic [ADDR_WIDTH-1:0] sram_awaddr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [STRB_WIDTH-1:0] sram_wstrb;
    logic                  sram_wen;
    logic [1:0]            sram_bresp;
    logic                  sram_bvalid;

    modport slave (
        input  ifu_arvalid, ifu_araddr,
        output ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
        input  lsu_arvalid, lsu_araddr,
        output lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
        input  lsu_awvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
        output lsu_awready, lsu_bvalid, lsu_bresp,
        output sram_araddr, sram_ren,
        input  sram_rdata, sram_rresp, sram_rvalid,
        output sram_awaddr, sram_wdata, sram_wstrb, sram_wen,
        input  sram_bresp, sram_bvalid
    );

    modport master (
        output ifu_arvalid, ifu_araddr,
        input  ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
        output lsu_arvalid, lsu_araddr,
        input  lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
        output lsu_awvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
        input  lsu_awready, lsu_bvalid, lsu_bresp,
        input  sram_araddr, sram_ren,
        output sram_rdata, sram_rresp, sram_rvalid,
        input  sram_awaddr, sram_wdata, sram_wstrb, sram_wen,
        output sram_bresp, sram_bvalid
    );

endinterface

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_arbiter
// Two-master arbiter/sequencer in front of the single-port SRAM model.
// One transaction at a time: accept (IDLE), strobe SRAM for one cycle
// (ISSUE), then forward the SRAM response to the owning master (WAIT).
// Grant priority in IDLE: LSU write > LSU read > IFU read.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (aborts any transaction)
//   bus_io : ysyx_24110015_mem_arbiter_if.slave, all master/SRAM channels
//
// Configuration macro: YSYX_24110015_ARB_TIMEOUT_EN
//   When defined, a WAIT-cycle counter answers the owner with SLVERR once it
//   reaches TIMEOUT without an SRAM response. The TIMEOUT parameter only
//   exists in that build.
// ---------------------------------------------------------------------------
module ysyx_24110015_mem_arbiter
    import ysyx_24110015_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef YSYX_24110015_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 255
`endif
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_24110015_mem_arbiter_if.slave   bus_io
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    op_e                   op_q,    op_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

    // Response produced in WAIT, before it is routed to the owner.
    logic                  rdValid;
    logic [DATA_WIDTH-1:0] rdData;
    logic [1:0]            rdResp;
    logic                  wrValid;
    logic [1:0]            wrResp;

`ifdef YSYX_24110015_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeoutHit;

    assign timeoutHit = (cnt_q == CNT_W'(TIMEOUT));

    // WAIT-cycle counter; cleared whenever the FSM is not lingering in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Transaction registers: state plus the fields latched at grant time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // SRAM address/data always reflect the latched transaction, so they are
    // stable around the single-cycle strobe.
    assign bus_io.sram_araddr = addr_q;
    assign bus_io.sram_awaddr = addr_q;
    assign bus_io.sram_wdata  = wdata_q;
    assign bus_io.sram_wstrb  = wstrb_q;

    // Next-state, grant and response generation. Readies are gated by rst so
    // every output is 0 while reset is held, even with a request pending.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        bus_io.ifu_arready = 1'b0;
        bus_io.lsu_arready = 1'b0;
        bus_io.lsu_awready = 1'b0;
        bus_io.sram_ren    = 1'b0;
        bus_io.sram_wen    = 1'b0;

        rdValid = 1'b0;
        rdData  = '0;
        rdResp  = RESP_OKAY;
        wrValid = 1'b0;
        wrResp  = RESP_OKAY;
`ifdef YSYX_24110015_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif

        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (bus_io.lsu_awvalid) begin
                        bus_io.lsu_awready = 1'b1;
                        owner_d = OWN_LSU;
                        op_d    = OP_WR;
                        addr_d  = bus_io.lsu_awaddr;
                        wdata_d = bus_io.lsu_wdata;
                        wstrb_d = bus_io.lsu_wstrb;
                        state_d = ISSUE;
                    end else if (bus_io.lsu_arvalid) begin
                        bus_io.lsu_arready = 1'b1;
                        owner_d = OWN_LSU;
                        op_d    = OP_RD;
                        addr_d  = bus_io.lsu_araddr;
                        wdata_d = '0;
                        wstrb_d = '0;
                        state_d = ISSUE;
                    end else if (bus_io.ifu_arvalid) begin
                        bus_io.ifu_arready = 1'b1;
                        owner_d = OWN_IFU;
                        op_d    = OP_RD;
                        addr_d  = bus_io.ifu_araddr;
                        wdata_d = '0;
                        wstrb_d = '0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                bus_io.sram_ren = (op_q == OP_RD);
                bus_io.sram_wen = (op_q == OP_WR);
                state_d = WAIT;
            end
            WAIT: begin
                if ((op_q == OP_RD) && bus_io.sram_rvalid) begin
                    rdValid = 1'b1;
                    rdData  = bus_io.sram_rdata;
                    rdResp  = bus_io.sram_rresp;
                    state_d = IDLE;
                end else if ((op_q == OP_WR) && bus_io.sram_bvalid) begin
                    wrValid = 1'b1;
                    wrResp  = bus_io.sram_bresp;
                    state_d = IDLE;
                end
`ifdef YSYX_24110015_ARB_TIMEOUT_EN
                else if (timeoutHit) begin
                    rdValid = (op_q == OP_RD);
                    wrValid = (op_q == OP_WR);
                    rdData  = '0;
                    rdResp  = RESP_SLVERR;
                    wrResp  = RESP_SLVERR;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Route the response to the owner only; the other side stays 0.
        bus_io.ifu_rvalid = rdValid && (owner_q == OWN_IFU);
        bus_io.ifu_rdata  = bus_io.ifu_rvalid ? rdData : '0;
        bus_io.ifu_rresp  = bus_io.ifu_rvalid ? rdResp : RESP_OKAY;
        bus_io.lsu_rvalid = rdValid && (owner_q == OWN_LSU);
        bus_io.lsu_rdata  = bus_io.lsu_rvalid ? rdData : '0;
        bus_io.lsu_rresp  = bus_io.lsu_rvalid ? rdResp : RESP_OKAY;
        bus_io.lsu_bvalid = wrValid && (owner_q == OWN_LSU);
        bus_io.lsu_bresp  = bus_io.lsu_bvalid ? wrResp : RESP_OKAY;
    end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110015_mem_arbiter
// Directed bench for the IFU/LSU memory arbiter. Inputs change 2 time units
// after each rising edge and outputs are sampled 1 unit later, well away
// from the edges. With YSYX_24110015_ARB_TIMEOUT_EN defined the DUT is built
// with TIMEOUT = 4 and the watchdog response is exercised; otherwise the
// bench shows that WAIT holds until reset.
// ---------------------------------------------------------------------------
module tb_ysyx_24110015_mem_arbiter;

    logic clk;
    logic rst;

    int vecCount = 0;
    int errCount = 0;

    ysyx_24110015_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_24110015_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
`ifdef YSYX_24110015_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(4)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Master-side request inputs.
    task automatic applyStimulus(input logic ifuV, input logic [31:0] ifuA,
                                 input logic lsuArV, input logic [31:0] lsuArA,
                                 input logic lsuAwV, input logic [31:0] lsuAwA,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.ifu_arvalid = ifuV;
        bus.ifu_araddr  = ifuA;
        bus.lsu_arvalid = lsuArV;
        bus.lsu_araddr  = lsuArA;
        bus.lsu_awvalid = lsuAwV;
        bus.lsu_awaddr  = lsuAwA;
        bus.lsu_wdata   = wdata;
        bus.lsu_wstrb   = wstrb;
    endtask

    // SRAM-side response inputs.
    task automatic setSram(input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                           input logic bv, input logic [1:0] br);
        bus.sram_rvalid = rv;
        bus.sram_rdata  = rd;
        bus.sram_rresp  = rr;
        bus.sram_bvalid = bv;
        bus.sram_bresp  = br;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);

        // Reset state: all outputs 0, even with an IFU request pending.
        #12;
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("rst_ren",       bus.sram_ren,    0);
        checkOutput("rst_wen",       bus.sram_wen,    0);
        checkOutput("rst_araddr",    bus.sram_araddr, 0);
        checkOutput("rst_awaddr",    bus.sram_awaddr, 0);
        checkOutput("rst_wdata",     bus.sram_wdata,  0);
        checkOutput("rst_wstrb",     bus.sram_wstrb,  0);
        checkOutput("rst_ifu_ready", bus.ifu_arready, 0);
        checkOutput("rst_aw_ready",  bus.lsu_awready, 0);
        checkOutput("rst_ifu_rv",    bus.ifu_rvalid,  0);
        checkOutput("rst_lsu_bv",    bus.lsu_bvalid,  0);

        // IFU read alone.
        rst = 1'b0;
        #1;
        checkOutput("t1_ifu_arready", bus.ifu_arready, 1);
        checkOutput("t1_lsu_arready", bus.lsu_arready, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t1_ren",        bus.sram_ren,    1);
        checkOutput("t1_wen",        bus.sram_wen,    0);
        checkOutput("t1_araddr",     bus.sram_araddr, 32'h8000_0000);
        checkOutput("t1_ready_iss",  bus.ifu_arready, 0);
        tick();
        setSram(1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 2'b00);
        #1;
        checkOutput("t1_ifu_rvalid", bus.ifu_rvalid, 1);
        checkOutput("t1_ifu_rdata",  bus.ifu_rdata,  32'hDEAD_BEEF);
        checkOutput("t1_ifu_rresp",  bus.ifu_rresp,  0);
        checkOutput("t1_lsu_rvalid", bus.lsu_rvalid, 0);
        checkOutput("t1_lsu_rdata",  bus.lsu_rdata,  0);
        checkOutput("t1_ren_wait",   bus.sram_ren,   0);
        tick();
        // Spurious SRAM valid while IDLE must be ignored.
        setSram(1'b1, 32'hFFFF_FFFF, 2'b00, 1'b1, 2'b00);
        #1;
        checkOutput("t1_idle_ifu_rv", bus.ifu_rvalid, 0);
        checkOutput("t1_idle_rdata",  bus.ifu_rdata,  0);
        checkOutput("t1_idle_bv",     bus.lsu_bvalid, 0);

        // IFU read and LSU write together: write wins.
        tick();
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);
        applyStimulus(1'b1, 32'h8000_0004, 1'b0, '0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
        #1;
        checkOutput("t2_awready",  bus.lsu_awready, 1);
        checkOutput("t2_ifu_rdy0", bus.ifu_arready, 0);
        tick();
        applyStimulus(1'b1, 32'h8000_0004, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t2_wen",      bus.sram_wen,    1);
        checkOutput("t2_ren",      bus.sram_ren,    0);
        checkOutput("t2_awaddr",   bus.sram_awaddr, 32'h8000_0010);
        checkOutput("t2_wdata",    bus.sram_wdata,  32'h1234_5678);
        checkOutput("t2_wstrb",    bus.sram_wstrb,  4'b0011);
        checkOutput("t2_ifu_rdy1", bus.ifu_arready, 0);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b1, 2'b00);
        #1;
        checkOutput("t2_bvalid",   bus.lsu_bvalid, 1);
        checkOutput("t2_bresp",    bus.lsu_bresp,  0);
        checkOutput("t2_ifu_rv",   bus.ifu_rvalid, 0);
        checkOutput("t2_wen_wait", bus.sram_wen,   0);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);
        #1;
        checkOutput("t2_bvalid_off", bus.lsu_bvalid,  0);
        checkOutput("t2_ifu_rdy2",   bus.ifu_arready, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t2_ifu_ren",    bus.sram_ren,    1);
        checkOutput("t2_ifu_araddr", bus.sram_araddr, 32'h8000_0004);
        tick();
        setSram(1'b1, 32'h0BAD_F00D, 2'b00, 1'b0, 2'b00);
        #1;
        checkOutput("t2_ifu_rvalid", bus.ifu_rvalid, 1);
        checkOutput("t2_ifu_rdata",  bus.ifu_rdata,  32'h0BAD_F00D);
        checkOutput("t2_lsu_bv0",    bus.lsu_bvalid, 0);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);

        // LSU write and LSU read together; read returns SLVERR.
        applyStimulus(1'b0, '0, 1'b1, 32'h8000_0040, 1'b1, 32'h8000_0044, 32'hA5A5_A5A5, 4'b1111);
        #1;
        checkOutput("t3_awready", bus.lsu_awready, 1);
        checkOutput("t3_arready", bus.lsu_arready, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 32'h8000_0040, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t3_wen",     bus.sram_wen,    1);
        checkOutput("t3_awaddr",  bus.sram_awaddr, 32'h8000_0044);
        checkOutput("t3_ar_iss",  bus.lsu_arready, 0);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b1, 2'b01);
        #1;
        checkOutput("t3_bvalid",  bus.lsu_bvalid,  1);
        checkOutput("t3_bresp",   bus.lsu_bresp,   2'b01);
        checkOutput("t3_ar_wait", bus.lsu_arready, 0);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);
        #1;
        checkOutput("t3_arready2", bus.lsu_arready, 1);
        checkOutput("t3_awready2", bus.lsu_awready, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t3_ren",    bus.sram_ren,    1);
        checkOutput("t3_araddr", bus.sram_araddr, 32'h8000_0040);
        tick();
        setSram(1'b1, 32'hCAFE_0001, 2'b10, 1'b0, 2'b00);
        #1;
        checkOutput("t3_lsu_rvalid", bus.lsu_rvalid, 1);
        checkOutput("t3_lsu_rresp",  bus.lsu_rresp,  2'b10);
        checkOutput("t3_lsu_rdata",  bus.lsu_rdata,  32'hCAFE_0001);
        checkOutput("t3_ifu_rvalid", bus.ifu_rvalid, 0);
        checkOutput("t3_ifu_rdata",  bus.ifu_rdata,  0);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h8000_0060, 32'h0000_00FF, 4'b0001);
        #1;
        checkOutput("t3_back_idle", bus.lsu_awready, 1);

        // Reset during ISSUE drops the write strobe at once.
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t4_wen_pre", bus.sram_wen, 1);
        rst = 1'b1;
        #1;
        checkOutput("t4_wen_rst", bus.sram_wen, 0);
        rst = 1'b0;
        tick();

        // Reset during WAIT kills the response in flight.
        applyStimulus(1'b1, 32'h8000_0070, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t4_ifu_rdy", bus.ifu_arready, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        tick();
        setSram(1'b1, 32'h5555_5555, 2'b00, 1'b0, 2'b00);
        #1;
        checkOutput("t4_rv_pre", bus.ifu_rvalid, 1);
        rst = 1'b1;
        #1;
        checkOutput("t4_rv_rst",    bus.ifu_rvalid, 0);
        checkOutput("t4_rdata_rst", bus.ifu_rdata,  0);
        checkOutput("t4_ren_rst",   bus.sram_ren,   0);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);
        rst = 1'b0;
        tick();

        // Fresh IFU read after reset.
        applyStimulus(1'b1, 32'h8000_0030, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t4_new_rdy", bus.ifu_arready, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t4_new_ren",    bus.sram_ren,    1);
        checkOutput("t4_new_araddr", bus.sram_araddr, 32'h8000_0030);
        tick();
        setSram(1'b1, 32'h1122_3344, 2'b00, 1'b0, 2'b00);
        #1;
        checkOutput("t4_new_rvalid", bus.ifu_rvalid, 1);
        checkOutput("t4_new_rdata",  bus.ifu_rdata,  32'h1122_3344);
        tick();
        setSram(1'b0, '0, 2'b00, 1'b0, 2'b00);

        // SRAM never answers an IFU read.
        applyStimulus(1'b1, 32'h8000_0050, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t5_rdy", bus.ifu_arready, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t5_ren", bus.sram_ren, 1);
`ifdef YSYX_24110015_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checkOutput("t5_wait_rv", bus.ifu_rvalid, 0);
        end
        tick();
        #1;
        checkOutput("t5_to_rvalid", bus.ifu_rvalid, 1);
        checkOutput("t5_to_rresp",  bus.ifu_rresp,  2'b10);
        checkOutput("t5_to_rdata",  bus.ifu_rdata,  0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h8000_0080, '0, '0);
        #1;
        checkOutput("t5_to_rv_off", bus.ifu_rvalid,  0);
        checkOutput("t5_to_idle",   bus.lsu_awready, 1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
`else
        // WAIT persists and blocks new requests until reset.
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h8000_0080, '0, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            checkOutput("t5_stall_rv",  bus.ifu_rvalid,  0);
            checkOutput("t5_stall_rdy", bus.lsu_awready, 0);
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t5_recover_rdy", bus.lsu_awready, 1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_mem_arbiter.md
# ysyx_24110015_mem_arbiter

Two-master arbiter and sequencer in front of the single-port `ysyx_24110015_SRAM` memory model. It is shared between the IFU (read-only) and the LSU (read/write). It accepts one request at a time and drives the SRAM `ren`/`wen` strobes for exactly one cycle. It then waits for the SRAM `rvalid`/`bvalid` and routes the response back to the requester.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT, 255, WAIT-cycle limit; used only with the timeout macro
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_arvalid / ifu_araddr  in  1 / ADDR_WIDTH  IFU read request
- ifu_arready  out  1  IFU request accepted this cycle
- ifu_rvalid / ifu_rdata / ifu_rresp  out  1 / DATA_WIDTH / 2  IFU read response, one-cycle pulse
- lsu_arvalid / lsu_araddr  in  1 / ADDR_WIDTH  LSU read request
- lsu_arready  out  1  LSU read accepted
- lsu_awvalid / lsu_awaddr / lsu_wdata / lsu_wstrb  in  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  LSU write request
- lsu_awready  out  1  LSU write accepted
- lsu_rvalid / lsu_rdata / lsu_rresp  out  1 / DATA_WIDTH / 2  LSU read response pulse
- lsu_bvalid / lsu_bresp  out  1 / 2  LSU write response pulse
- sram_araddr / sram_ren  out  ADDR_WIDTH / 1  SRAM read port
- sram_rdata / sram_rresp / sram_rvalid  in  DATA_WIDTH / 2 / 1  SRAM read response
- sram_awaddr / sram_wdata / sram_wstrb / sram_wen  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8 / 1  SRAM write port
- sram_bresp / sram_bvalid  in  2 / 1  SRAM write response

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Grant uses fixed priority: LSU write > LSU read > IFU read.
  - The matching `*_ready` is asserted combinationally in the same cycle.
  - On that edge the arbiter latches owner, op, addr, wdata and wstrb, then moves to ISSUE.
  - With no request, it stays in IDLE and all readies are 0.
- ISSUE:
  - Drives `sram_ren` (read) or `sram_wen` (write) high for exactly one cycle, using the latched fields.
  - Moves to WAIT.
  - `sram_*` address/data/strb outputs hold the latched values in every state.
- WAIT:
  - Slave `rvalid` (read op) or `bvalid` (write op) is forwarded combinationally to the owner only.
  - Data and resp pass through unchanged, including nonzero resp.
  - On the same edge the FSM returns to IDLE.
- Requests are not accepted in ISSUE or WAIT; all readies are 0 there.
- A master must hold valid and its fields stable until ready.
- Slave valids arriving in IDLE or ISSUE are ignored.
- Response pulses are exactly one cycle and have no backpressure; masters must sink them.
- Non-owner response outputs stay 0; rdata outputs are 0 when their rvalid is 0.
- Simultaneous `lsu_awvalid` and `lsu_arvalid`: the write wins and the read stays pending.

## Timing
- Reset: state IDLE; every output port 0, including `sram_ren`, `sram_wen`, addresses, data, strb, all readies and all response outputs; latched fields 0.
- Reset mid-transaction aborts the transaction.
  - `sram_ren`/`sram_wen` drop immediately (asynchronous).
  - No response is delivered to the master.
- Per transaction (accept in cycle 0):
  - Cycle 1: ISSUE.
  - Cycle 2: response, given the SRAM's 1-cycle latency.
  - Cycle 3: IDLE, next accept possible.
- Best-case throughput is one transaction per 3 cycles.
- SRAM strobes are never high for two consecutive cycles.

## Configuration
- `YSYX_24110015_ARB_TIMEOUT_EN` defined:
  - WAIT counts cycles from 0.
  - When the count reaches TIMEOUT with no slave valid, the owner gets a response pulse with resp = 2'b10 (SLVERR) and rdata = 0.
  - The FSM returns to IDLE and the counter clears.
- Not defined: WAIT lasts indefinitely and no counter is instantiated.

## Structure
- Package `ysyx_24110015_arb_pkg`:
  - State enum (IDLE/ISSUE/WAIT).
  - Owner encoding (OWN_IFU, OWN_LSU).
  - Op encoding (OP_RD, OP_WR).
  - Resp constants (RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10).
- No sub-module: grant logic and the timeout counter stay inline.

## Test plan
- IFU read 0x8000_0000 alone, SRAM returns 0xDEAD_BEEF:
  - `ifu_arready` in cycle 0.
  - `sram_ren` in cycle 1 only.
  - `ifu_rvalid` with 0xDEAD_BEEF in cycle 2.
  - LSU outputs 0 throughout.
- IFU read and LSU write 0x8000_0010 (data 0x1234_5678, strb 4'b0011) in the same cycle:
  - LSU granted first; `sram_wen` with the latched fields; `lsu_bvalid` pulse.
  - IFU then accepted in cycle 3.
- LSU write and LSU read both valid: write completes first, then the read is accepted in cycle 3.
- SRAM returns rresp = 2'b10: `lsu_rresp` = 2'b10 forwarded; FSM returns to IDLE.
- `rst` asserted during WAIT:
  - `sram_ren`/`sram_wen`, readies and responses go to 0 immediately.
  - After release, a fresh IFU read completes normally.
- With the macro defined and TIMEOUT = 4, SRAM never responds: at WAIT cycle 4 `ifu_rvalid` = 1, `ifu_rresp` = 2'b10, `ifu_rdata` = 0; next cycle in IDLE.
